// File: rtl/ob_cntrl_mk_exec.sv
// Market-order execution controller: query the trade decision block, emit a trade record,
// then strobe queue pops / head updates. Optional counters via OB_CNTRL_MK_EXEC_STATS_EN.
module ob_cntrl_mk_exec #(
   parameter int UID_W      = 32,
   parameter int PRICE_W    = 20,
   parameter int QUANTITY_W = 16,
   parameter int MAX_TRADES = 0,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   output logic                  trade_qry,
   input  logic                  trade_vld_r,
   input  logic                  trade_mk_ask_lm_bid,
   input  logic                  trade_lm_ask_mk_bid,
   input  logic                  trade_mk_ask_mk_bid,
   input  logic [UID_W-1:0]      trade_ask_uid,
   input  logic [UID_W-1:0]      trade_bid_uid,
   input  logic [PRICE_W-1:0]    trade_ask_price,
   input  logic [PRICE_W-1:0]    trade_bid_price,
   input  logic                  trade_ask_consumed,
   input  logic                  trade_bid_consumed,
   input  logic [QUANTITY_W-1:0] trade_quantity,
   input  logic [QUANTITY_W-1:0] trade_remainder,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [UID_W-1:0]      rsp_ask_uid,
   output logic [UID_W-1:0]      rsp_bid_uid,
   output logic [PRICE_W-1:0]    rsp_price,
   output logic [QUANTITY_W-1:0] rsp_quantity,
   output logic                  mk_ask_pop,
   output logic                  mk_bid_pop,
   output logic                  lm_ask_pop,
   output logic                  lm_bid_pop,
   output logic                  mk_ask_upd,
   output logic                  mk_bid_upd,
   output logic                  lm_ask_upd,
   output logic                  lm_bid_upd,
   output logic [QUANTITY_W-1:0] upd_quantity,
   output logic                  busy,
   output logic                  done,
   output logic                  err_r
`ifdef OB_CNTRL_MK_EXEC_STATS_EN
   ,
   output logic [31:0]           stat_trades_r,
   output logic [47:0]           stat_quantity_r
`endif
);

   typedef enum logic [2:0] {S_IDLE, S_QRY, S_WAIT, S_EMIT, S_UPD, S_SETTLE} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRADES);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic                    capture;
   logic                    upd_en;
   logic                    legal;
   logic [UID_W-1:0]        ask_uid_q, bid_uid_q;
   logic [PRICE_W-1:0]      price_q;
   logic [QUANTITY_W-1:0]   qty_q, rem_q;
   logic                    ask_c_q, bid_c_q;
   logic                    ask_mk_q, bid_mk_q;

   assign legal = $onehot({trade_mk_ask_lm_bid, trade_lm_ask_mk_bid, trade_mk_ask_mk_bid})
                  && (trade_ask_consumed || trade_bid_consumed);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      capture   = 1'b0;
      upd_en    = 1'b0;
      trade_qry = 1'b0;
      rsp_vld   = 1'b0;
      done      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (en) begin
               state_d = S_QRY;
               cnt_d   = '0;
            end
         end
         S_QRY: begin
            trade_qry = 1'b1;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (!trade_vld_r) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else if (!legal) begin
               err_d   = 1'b1;
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               capture = 1'b1;
               state_d = S_EMIT;
            end
         end
         S_EMIT: begin
            rsp_vld = 1'b1;
            if (rsp_rdy) state_d = S_UPD;
         end
         S_UPD: begin
            upd_en  = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (!en || (MAX_TRADES != 0 && cnt_q == MAX_CNT)) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_QRY;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         ask_uid_q <= '0;
         bid_uid_q <= '0;
         price_q   <= '0;
         qty_q     <= '0;
         rem_q     <= '0;
         ask_c_q   <= 1'b0;
         bid_c_q   <= 1'b0;
         ask_mk_q  <= 1'b0;
         bid_mk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (capture) begin
            ask_uid_q <= trade_ask_uid;
            bid_uid_q <= trade_bid_uid;
            // The execution price is always taken from the limit side when one exists.
            price_q   <= trade_mk_ask_lm_bid ? trade_bid_price : trade_ask_price;
            qty_q     <= trade_quantity;
            rem_q     <= trade_remainder;
            ask_c_q   <= trade_ask_consumed;
            bid_c_q   <= trade_bid_consumed;
            ask_mk_q  <= !trade_lm_ask_mk_bid;
            bid_mk_q  <= !trade_mk_ask_lm_bid;
         end
      end
   end

   assign rsp_ask_uid  = ask_uid_q;
   assign rsp_bid_uid  = bid_uid_q;
   assign rsp_price    = price_q;
   assign rsp_quantity = qty_q;
   assign busy         = (state_q != S_IDLE);
   assign err_r        = err_q;

   assign mk_ask_pop = upd_en &&  ask_mk_q &&  ask_c_q;
   assign lm_ask_pop = upd_en && !ask_mk_q &&  ask_c_q;
   assign mk_ask_upd = upd_en &&  ask_mk_q && !ask_c_q;
   assign lm_ask_upd = upd_en && !ask_mk_q && !ask_c_q;
   assign mk_bid_pop = upd_en &&  bid_mk_q &&  bid_c_q;
   assign lm_bid_pop = upd_en && !bid_mk_q &&  bid_c_q;
   assign mk_bid_upd = upd_en &&  bid_mk_q && !bid_c_q;
   assign lm_bid_upd = upd_en && !bid_mk_q && !bid_c_q;
   assign upd_quantity = (upd_en && !(ask_c_q && bid_c_q)) ? rem_q : '0;

`ifdef OB_CNTRL_MK_EXEC_STATS_EN
   logic [31:0] stat_trades_q;
   logic [47:0] stat_qty_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_trades_q <= '0;
         stat_qty_q    <= '0;
      end else if (upd_en) begin
         if (stat_trades_q != '1) stat_trades_q <= stat_trades_q + 32'd1;
         stat_qty_q <= stat_qty_q + 48'(qty_q);
      end
   end

   assign stat_trades_r   = stat_trades_q;
   assign stat_quantity_r = stat_qty_q;
`endif

endmodule

// File: tb/tb_ob_cntrl_mk_exec.sv
// Self-checking bench for ob_cntrl_mk_exec: event-timeline reference model driven by
// directed and randomized trade decisions.
module tb_ob_cntrl_mk_exec;
   localparam int MAXT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, en, trade_qry, trade_vld_r;
   logic        trade_mk_ask_lm_bid, trade_lm_ask_mk_bid, trade_mk_ask_mk_bid;
   logic [31:0] trade_ask_uid, trade_bid_uid, rsp_ask_uid, rsp_bid_uid;
   logic [19:0] trade_ask_price, trade_bid_price, rsp_price;
   logic        trade_ask_consumed, trade_bid_consumed;
   logic [15:0] trade_quantity, trade_remainder, rsp_quantity, upd_quantity;
   logic        rsp_vld, rsp_rdy;
   logic        mk_ask_pop, mk_bid_pop, lm_ask_pop, lm_bid_pop;
   logic        mk_ask_upd, mk_bid_upd, lm_ask_upd, lm_bid_upd;
   logic        busy, done, err_r;

   ob_cntrl_mk_exec #(.MAX_TRADES(MAXT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .trade_qry(trade_qry), .trade_vld_r(trade_vld_r),
      .trade_mk_ask_lm_bid(trade_mk_ask_lm_bid), .trade_lm_ask_mk_bid(trade_lm_ask_mk_bid),
      .trade_mk_ask_mk_bid(trade_mk_ask_mk_bid),
      .trade_ask_uid(trade_ask_uid), .trade_bid_uid(trade_bid_uid),
      .trade_ask_price(trade_ask_price), .trade_bid_price(trade_bid_price),
      .trade_ask_consumed(trade_ask_consumed), .trade_bid_consumed(trade_bid_consumed),
      .trade_quantity(trade_quantity), .trade_remainder(trade_remainder),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_ask_uid(rsp_ask_uid), .rsp_bid_uid(rsp_bid_uid),
      .rsp_price(rsp_price), .rsp_quantity(rsp_quantity),
      .mk_ask_pop(mk_ask_pop), .mk_bid_pop(mk_bid_pop), .lm_ask_pop(lm_ask_pop), .lm_bid_pop(lm_bid_pop),
      .mk_ask_upd(mk_ask_upd), .mk_bid_upd(mk_bid_upd), .lm_ask_upd(lm_ask_upd), .lm_bid_upd(lm_bid_upd),
      .upd_quantity(upd_quantity), .busy(busy), .done(done), .err_r(err_r)
   );

   // kind[2]=mk_ask_lm_bid, kind[1]=lm_ask_mk_bid, kind[0]=mk_ask_mk_bid
   typedef struct packed {
      bit        vld;
      bit [2:0]  kind;
      bit [31:0] ask_uid, bid_uid;
      bit [19:0] ask_price, bid_price;
      bit        ask_c, bid_c;
      bit [15:0] qty, rem;
   } dec_t;

   dec_t dq[$];
   dec_t cur;
   int   cyc, n_cmp, n_fail;
   int   exp_qry, exp_done, exp_strobe, rsp_start, settle_cyc, err_at, trades;
   bit   rsp_active, idle_model, exp_err;
   bit   en_drive, en_rand, rdy_rand, rst_drive;
   int   rdy_hold;
   int   n_rec, n_strobe, n_done, n_qry, n_rspcyc;
   int   qry_last, qry_gap, done_cyc, start_cyc, accept_cyc, strobe_cyc;
   logic [7:0]  first_strb;
   logic [15:0] first_updq, first_qty;
   logic [19:0] first_price;

   function automatic bit legal(input dec_t d);
      return ($countones(d.kind) == 1) && (d.ask_c || d.bid_c);
   endfunction

   function automatic logic [19:0] exp_price(input dec_t d);
      return d.kind[2] ? d.bid_price : d.ask_price;
   endfunction

   // Strobe vector {pops mk_ask,mk_bid,lm_ask,lm_bid ; upds in the same order}
   function automatic logic [7:0] exp_strb(input dec_t d);
      logic [7:0] v;
      int ask_idx, bid_idx;
      v = 8'h00;
      ask_idx = d.kind[1] ? 2 : 0;
      bid_idx = d.kind[2] ? 3 : 1;
      v[(d.ask_c ? 7 : 3) - ask_idx] = 1'b1;
      v[(d.bid_c ? 7 : 3) - bid_idx] = 1'b1;
      return v;
   endfunction

   function automatic dec_t rand_dec();
      dec_t d;
      int c;
      d.vld       = 1'b1;
      d.kind      = 3'b001 << $urandom_range(0, 2);
      d.ask_uid   = $urandom;
      d.bid_uid   = $urandom;
      d.ask_price = 20'($urandom);
      d.bid_price = 20'($urandom);
      c           = $urandom_range(0, 2);
      d.ask_c     = (c != 1);
      d.bid_c     = (c != 0);
      d.qty       = 16'($urandom);
      d.rem       = 16'($urandom);
      return d;
   endfunction

   task automatic clr_obs();
      n_rec = 0; n_strobe = 0; n_done = 0; n_qry = 0; n_rspcyc = 0;
      qry_last = -1; qry_gap = -1; done_cyc = -1; start_cyc = -1; accept_cyc = -1; strobe_cyc = -1;
   endtask

   task automatic step();
      dec_t d;
      logic [7:0] strb_obs, strb_exp;
      bit rsp_exp, busy_exp;
      @(posedge clk); #1;
      cyc++;
      en    = (en_rand && !idle_model) ? ($urandom_range(0, 4) != 0) : en_drive;
      rst_n = !rst_drive;
      busy_exp = !idle_model;
      if (cyc == err_at) exp_err = 1'b1;
      if (rst_n && idle_model && en) begin
         exp_qry = cyc + 1; idle_model = 1'b0; trades = 0; start_cyc = cyc;
      end
      trade_vld_r = 1'b0;
      {trade_mk_ask_lm_bid, trade_lm_ask_mk_bid, trade_mk_ask_mk_bid} = 3'($urandom);
      {trade_ask_consumed, trade_bid_consumed} = 2'($urandom);
      trade_ask_uid = $urandom; trade_bid_uid = $urandom;
      trade_ask_price = 20'($urandom); trade_bid_price = 20'($urandom);
      trade_quantity = 16'($urandom); trade_remainder = 16'($urandom);
      if (cyc == exp_qry + 1) begin
         d = '0;
         if (dq.size() > 0) d = dq.pop_front();
         trade_vld_r = d.vld;
         if (d.vld) begin
            {trade_mk_ask_lm_bid, trade_lm_ask_mk_bid, trade_mk_ask_mk_bid} = d.kind;
            trade_ask_uid = d.ask_uid; trade_bid_uid = d.bid_uid;
            trade_ask_price = d.ask_price; trade_bid_price = d.bid_price;
            trade_ask_consumed = d.ask_c; trade_bid_consumed = d.bid_c;
            trade_quantity = d.qty; trade_remainder = d.rem;
         end
         if (!d.vld || !legal(d)) begin
            exp_done = cyc;
            if (d.vld) err_at = cyc + 1;
         end else begin
            cur = d; rsp_start = cyc + 1;
         end
      end
      if (cyc == rsp_start) rsp_active = 1'b1;
      rsp_exp = rsp_active;
      if (!rsp_active) rsp_rdy = 1'($urandom_range(0, 1));
      else if (rdy_hold > 0) begin rsp_rdy = 1'b0; rdy_hold--; end
      else rsp_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_active && rsp_rdy && rst_n) begin
         exp_strobe = cyc + 1; settle_cyc = cyc + 2; rsp_active = 1'b0;
         n_rec++; accept_cyc = cyc;
      end
      if (cyc == exp_strobe) trades++;
      if (cyc == settle_cyc) begin
         if (trades == MAXT || !en) exp_done = cyc;
         else exp_qry = cyc + 1;
      end

      @(negedge clk);
      strb_obs = {mk_ask_pop, mk_bid_pop, lm_ask_pop, lm_bid_pop, mk_ask_upd, mk_bid_upd, lm_ask_upd, lm_bid_upd};
      strb_exp = (cyc == exp_strobe) ? exp_strb(cur) : 8'h00;
      n_cmp++;
      if (trade_qry !== (cyc == exp_qry)) begin
         n_fail++; $display("FAIL qry cyc=%0d got=%b want=%b", cyc, trade_qry, (cyc == exp_qry));
      end
      n_cmp++;
      if (done !== (cyc == exp_done)) begin
         n_fail++; $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, (cyc == exp_done));
      end
      n_cmp++;
      if (busy !== busy_exp) begin
         n_fail++; $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, busy_exp);
      end
      n_cmp++;
      if (rsp_vld !== rsp_exp) begin
         n_fail++; $display("FAIL rsp_vld cyc=%0d got=%b want=%b", cyc, rsp_vld, rsp_exp);
      end
      if (rsp_exp) begin
         n_cmp++;
         if ({rsp_ask_uid, rsp_bid_uid, rsp_price, rsp_quantity} !== {cur.ask_uid, cur.bid_uid, exp_price(cur), cur.qty}) begin
            n_fail++;
            $display("FAIL rsp_rec cyc=%0d got=%h/%h/%h/%h want=%h/%h/%h/%h", cyc, rsp_ask_uid, rsp_bid_uid,
                     rsp_price, rsp_quantity, cur.ask_uid, cur.bid_uid, exp_price(cur), cur.qty);
         end
      end
      n_cmp++;
      if (strb_obs !== strb_exp) begin
         n_fail++; $display("FAIL strobes cyc=%0d got=%b want=%b", cyc, strb_obs, strb_exp);
      end
      if (strb_exp[3:0] != 4'h0) begin
         n_cmp++;
         if (upd_quantity !== cur.rem) begin
            n_fail++; $display("FAIL upd_quantity cyc=%0d got=%0d want=%0d", cyc, upd_quantity, cur.rem);
         end
      end
      n_cmp++;
      if (err_r !== exp_err) begin
         n_fail++; $display("FAIL err_r cyc=%0d got=%b want=%b", cyc, err_r, exp_err);
      end
      $display("cyc=%0d en=%b qry=%b vld_r=%b rsp_vld=%b rdy=%b strb=%b done=%b busy=%b err=%b",
               cyc, en, trade_qry, trade_vld_r, rsp_vld, rsp_rdy, strb_obs, done, busy, err_r);

      if (trade_qry === 1'b1) begin
         n_qry++;
         if (qry_last >= 0) qry_gap = cyc - qry_last;
         qry_last = cyc;
      end
      if (done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (rsp_vld === 1'b1) begin
         if (n_rspcyc == 0) begin first_price = rsp_price; first_qty = rsp_quantity; end
         n_rspcyc++;
      end
      if (strb_obs != 8'h00) begin
         if (n_strobe == 0) begin first_strb = strb_obs; first_updq = upd_quantity; end
         n_strobe++; strobe_cyc = cyc;
      end
      if (cyc == exp_done) idle_model = 1'b1;
      if (!rst_n) begin
         idle_model = 1'b1; rsp_active = 1'b0; exp_err = 1'b0;
         exp_qry = -10; exp_done = -10; exp_strobe = -10; rsp_start = -10; settle_cyc = -10; err_at = -10;
      end
   endtask

   task automatic run_burst(input bit rnd);
      int budget;
      clr_obs();
      en_drive = 1'b1; en_rand = rnd; rdy_rand = rnd;
      budget = 0;
      do begin step(); budget++; end while (n_done == 0 && budget < 300);
      if (n_done == 0) begin
         n_cmp++; n_fail++; $display("FAIL burst_timeout got=no_done want=done");
      end
      en_drive = 1'b0; en_rand = 1'b0; rdy_rand = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_reset();
      rst_drive = 1'b1;
      repeat (3) step();
      n_cmp++;
      if ({trade_qry, rsp_vld, busy, done, err_r, mk_ask_pop, mk_bid_pop, lm_ask_pop, lm_bid_pop,
           mk_ask_upd, mk_bid_upd, lm_ask_upd, lm_bid_upd, rsp_ask_uid, rsp_bid_uid, rsp_price,
           rsp_quantity, upd_quantity} !== '0) begin
         n_fail++; $display("FAIL reset_outputs got=nonzero want=all_zero");
      end
      rst_drive = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_mk_ask_lm_bid();
      dec_t d;
      d = '0;
      d.vld = 1'b1; d.kind = 3'b100; d.ask_c = 1'b1; d.bid_c = 1'b0;
      d.qty = 16'd40; d.rem = 16'd60; d.bid_price = 20'h00105; d.ask_price = 20'h00099;
      d.ask_uid = 32'h0000_0A01; d.bid_uid = 32'h0000_0B01;
      dq.push_back(d);
      dq.push_back(rand_dec());
      run_burst(1'b0);
      n_cmp++;
      if (first_price !== 20'h00105 || first_qty !== 16'd40) begin
         n_fail++; $display("FAIL mk_lm_rec got=%h/%0d want=00105/40", first_price, first_qty);
      end
      n_cmp++;
      if (first_strb !== 8'b1000_0001 || first_updq !== 16'd60) begin
         n_fail++; $display("FAIL mk_lm_strobes got=%b/%0d want=10000001/60", first_strb, first_updq);
      end
      n_cmp++;
      if (qry_gap != 5 || n_rec != 2) begin
         n_fail++; $display("FAIL trade_period got=gap%0d/rec%0d want=gap5/rec2", qry_gap, n_rec);
      end
   endtask

   task automatic test_mk_ask_mk_bid();
      dec_t d;
      d = rand_dec();
      d.kind = 3'b001; d.ask_c = 1'b1; d.bid_c = 1'b1; d.qty = 16'd25;
      dq.push_back(d);
      run_burst(1'b0);
      n_cmp++;
      if (first_price !== d.ask_price || first_strb !== 8'b1100_0000) begin
         n_fail++; $display("FAIL mk_mk got=%h/%b want=%h/11000000", first_price, first_strb, d.ask_price);
      end
   endtask

   task automatic test_no_trade();
      dq.delete();
      run_burst(1'b0);
      n_cmp++;
      if (n_qry != 1 || done_cyc - start_cyc != 2 || n_rspcyc != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_trade got=qry%0d/lat%0d/rsp%0d/busy%b want=qry1/lat2/rsp0/busy0",
                  n_qry, done_cyc - start_cyc, n_rspcyc, busy);
      end
   endtask

   task automatic test_backpressure();
      dq.push_back(rand_dec());
      rdy_hold = 7;
      run_burst(1'b0);
      n_cmp++;
      if (n_rspcyc != 8 || strobe_cyc - accept_cyc != 1 || n_strobe != 1) begin
         n_fail++;
         $display("FAIL backpressure got=rsp%0d/dly%0d/strb%0d want=rsp8/dly1/strb1",
                  n_rspcyc, strobe_cyc - accept_cyc, n_strobe);
      end
   endtask

   task automatic test_max_trades();
      dec_t d;
      repeat (4) dq.push_back(rand_dec());
      run_burst(1'b0);
      dq.delete();
      n_cmp++;
      if (n_rec != 2 || n_strobe != 2 || n_done != 1) begin
         n_fail++; $display("FAIL max_trades got=rec%0d/strb%0d/done%0d want=2/2/1", n_rec, n_strobe, n_done);
      end
      d = rand_dec();
      d.kind = 3'b110;
      dq.push_back(d);
      run_burst(1'b0);
      n_cmp++;
      if (err_r !== 1'b1 || n_strobe != 0 || n_rspcyc != 0 || n_done != 1) begin
         n_fail++; $display("FAIL illegal_kind got=err%b/strb%0d/rsp%0d want=err1/0/0", err_r, n_strobe, n_rspcyc);
      end
   endtask

   task automatic test_random();
      dec_t d;
      for (int b = 0; b < 10; b++) begin
         for (int i = 0; i < 5; i++) begin
            d = rand_dec();
            if ($urandom_range(0, 5) == 0) d.vld = 1'b0;
            dq.push_back(d);
         end
         run_burst(1'b1);
         dq.delete();
      end
   endtask

   task automatic test_reset_mid_emit();
      int budget;
      clr_obs();
      dq.push_back(rand_dec());
      rdy_hold = 1000;
      en_drive = 1'b1;
      budget = 0;
      do begin step(); budget++; end while (n_rspcyc == 0 && budget < 20);
      if (n_rspcyc == 0) begin
         n_cmp++; n_fail++; $display("FAIL emit_timeout got=no_rsp want=rsp");
      end
      rst_drive = 1'b1; en_drive = 1'b0;
      step();
      rst_drive = 1'b0; rdy_hold = 0;
      step();
      n_cmp++;
      if (rsp_vld !== 1'b0 || busy !== 1'b0 || err_r !== 1'b0) begin
         n_fail++; $display("FAIL reset_emit got=vld%b/busy%b/err%b want=0/0/0", rsp_vld, busy, err_r);
      end
      repeat (4) step();
      n_cmp++;
      if (n_strobe != 0) begin
         n_fail++; $display("FAIL reset_emit_strobes got=%0d want=0", n_strobe);
      end
      dq.delete();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; rsp_rdy = 1'b0; trade_vld_r = 1'b0;
      trade_mk_ask_lm_bid = 1'b0; trade_lm_ask_mk_bid = 1'b0; trade_mk_ask_mk_bid = 1'b0;
      trade_ask_uid = '0; trade_bid_uid = '0; trade_ask_price = '0; trade_bid_price = '0;
      trade_ask_consumed = 1'b0; trade_bid_consumed = 1'b0; trade_quantity = '0; trade_remainder = '0;
      cyc = 0; n_cmp = 0; n_fail = 0;
      exp_qry = -10; exp_done = -10; exp_strobe = -10; rsp_start = -10; settle_cyc = -10; err_at = -10;
      trades = 0; rsp_active = 1'b0; idle_model = 1'b1; exp_err = 1'b0;
      en_drive = 1'b0; en_rand = 1'b0; rdy_rand = 1'b0; rst_drive = 1'b1; rdy_hold = 0;
      first_strb = '0; first_updq = '0; first_qty = '0; first_price = '0;
      clr_obs();

      test_reset();
      test_mk_ask_lm_bid();
      test_mk_ask_mk_bid();
      test_no_trade();
      test_backpressure();
      test_random();
      test_max_trades();
      test_reset_mid_emit();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/ob_cntrl_mk_exec.md
Name: ob_cntrl_mk_exec

Overview:
Consumer and initiator side of the market-order trade decision interface. Issues trade_qry, captures the registered trade decision one cycle later, and emits a trade record on a valid/ready egress. On egress acceptance it drives one-cycle pop/update strobes to the market queues and limit tables, then re-queries. It runs while en is high and ends a burst with done when no trade is possible or the burst cap is reached.

Parameters:
UID_W, 32, uid width.
PRICE_W, 20, BCD price width.
QUANTITY_W, 16, quantity width.
MAX_TRADES, 0, maximum trades per burst; 0 = unlimited.
CNT_W, 16, burst trade counter width.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
en  in  1  start/continue market matching
trade_qry  out  1  query strobe to the decision block
trade_vld_r  in  1  decision valid, exactly 1 cycle after trade_qry
trade_mk_ask_lm_bid  in  1  decision kind: market ask vs limit bid
trade_lm_ask_mk_bid  in  1  decision kind: limit ask vs market bid
trade_mk_ask_mk_bid  in  1  decision kind: market ask vs market bid
trade_ask_uid / trade_bid_uid  in  UID_W  ask and bid order uids
trade_ask_price / trade_bid_price  in  PRICE_W  ask and bid prices
trade_ask_consumed / trade_bid_consumed  in  1  side fully consumed
trade_quantity  in  QUANTITY_W  traded quantity
trade_remainder  in  QUANTITY_W  residual quantity on the surviving side
rsp_vld  out  1  trade record valid
rsp_rdy  in  1  egress ready
rsp_ask_uid / rsp_bid_uid  out  UID_W  trade record uids
rsp_price  out  PRICE_W  execution price
rsp_quantity  out  QUANTITY_W  executed quantity
mk_ask_pop, mk_bid_pop, lm_ask_pop, lm_bid_pop  out  1  head pop strobes
mk_ask_upd, mk_bid_upd, lm_ask_upd, lm_bid_upd  out  1  head quantity write strobes
upd_quantity  out  QUANTITY_W  new head quantity, qualified by any *_upd strobe
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse at burst end
err_r  out  1  sticky illegal-decision flag

Behaviour:
- Reset (rst_n=0 at a clk edge): FSM to IDLE; all outputs 0; burst counter 0; err_r cleared. Reset asserted mid-burst abandons the burst immediately. No strobe is issued in the reset cycle or the cycle after it.
- States: IDLE, QRY, WAIT, EMIT, UPD, SETTLE.
- IDLE: when en=1, go to QRY and clear the burst counter.
- QRY: trade_qry=1 for exactly one cycle, then go to WAIT.
- WAIT: sample the trade_* inputs.
  - trade_vld_r=0: pulse done, go to IDLE.
  - trade_vld_r=1 and the decision is legal: register the record, go to EMIT.
  - Illegal decision: set err_r, pulse done, go to IDLE. Illegal means the kind bits are not one-hot, or both consumed flags are 0.
- EMIT: rsp_vld=1. Record fields stay stable until rsp_vld&rsp_rdy. On acceptance go to UPD. rsp_rdy is ignored when rsp_vld=0.
- rsp_price:
  - trade_mk_ask_lm_bid: bid_price (limit side).
  - trade_lm_ask_mk_bid: ask_price (limit side).
  - trade_mk_ask_mk_bid: ask_price.
- UPD: exactly one cycle of strobes; increment the burst counter, saturating at 2^CNT_W-1.
  - Side mapping: the ask side is mk_ask for mk_ask_lm_bid and mk_ask_mk_bid, lm_ask for lm_ask_mk_bid. The bid side is lm_bid for mk_ask_lm_bid, mk_bid for the other two.
  - A consumed side pops.
  - A non-consumed side asserts its *_upd strobe with upd_quantity=trade_remainder.
  - Pop and upd are never asserted on the same structure. At most one upd strobe is active per cycle.
- SETTLE: one bubble cycle so head registers reflect the update.
  - en=0: pulse done, go to IDLE.
  - MAX_TRADES≠0 and counter==MAX_TRADES: pulse done, go to IDLE.
  - Otherwise go to QRY.
- en deasserted in EMIT or UPD: the current trade completes; the burst ends at SETTLE.
- Latency: en to first trade_qry is 1 cycle. trade_qry to rsp_vld is 2 cycles. Minimum trade period is 5 cycles with rsp_rdy=1.
- done is never asserted together with rsp_vld or any strobe.
- busy=1 in every state except IDLE.

Optional Feature:
OB_CNTRL_MK_EXEC_STATS_EN
- Defined: adds outputs stat_trades_r (32b, saturating, +1 per UPD) and stat_quantity_r (48b, wrapping, += rsp_quantity per UPD). Both reset to 0 and are never cleared by done.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- mk_ask_lm_bid, ask_consumed=1, bid_consumed=0, quantity=40, remainder=60, bid_price=0x00105, rsp_rdy=1 -> rsp {price 0x00105, qty 40}; mk_ask_pop=1 and lm_bid_upd=1 with upd_quantity=60 in the same single cycle; next trade_qry 5 cycles after the previous one.
- mk_ask_mk_bid, both consumed, quantity=25 -> rsp_price=ask_price; mk_ask_pop=1 and mk_bid_pop=1; no upd strobe.
- en=1, first trade_vld_r=0 -> exactly one trade_qry; done pulse 2 cycles after en; no rsp_vld; busy returns to 0.
- rsp_rdy held 0 for 7 cycles during EMIT -> rsp_vld and fields stable 8 cycles; no strobes until the accept cycle +1.
- MAX_TRADES=2, decision block always valid -> exactly 2 records and 2 UPD cycles, then done. Kind bits 2'b11 set on a third burst -> err_r=1, done pulse, no strobes.
- rst_n=0 asserted during EMIT -> next cycle rsp_vld=0, busy=0, no pop/upd ever issued for that trade.
